mem_access_unit: RTL and testbench

Load/store front end between the multicycle MIPS datapath and the word-wide `Memory` block. It accepts one byte, halfword or word request at a time and converts the byte address to the memory's word index. Sub-word stores are performed as read-modify-write sequences, and sub-word loads are returned sign- or zero-extended. It drives `Memory`'s `Address`, `writeData` and `writeEnable` inputs and consumes `MemData`.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_lane_merge.sv | 45 ++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store front end: size encodings, FSM states and
// the alignment helpers used by mem_access_unit.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  // Offending low address bits are dropped so the access lands on its natural boundary.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    logic [1:0] o;
    case (sz)
      SZ_BYTE: o = off;
      SZ_HALF: o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational big-endian lane logic: merges store data into a memory word
// and extracts/extends load data from it.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] ext
);

  logic [4:0]  bshift;
  logic [4:0]  hshift;
  logic [7:0]  bval;
  logic [15:0] hval;

  // Offset 0 is the most significant lane.
  assign bshift = {~off, 3'b000};
  assign hshift = {~off[1], 4'b0000};

  always_comb begin
    merged = old_word;
    ext    = old_word;
    bval   = old_word[bshift +: 8];
    hval   = old_word[hshift +: 16];
    case (size)
      SZ_BYTE: begin
        merged[bshift +: 8] = wdata[7:0];
        ext = {{24{sext & bval[7]}}, bval};
      end
      SZ_HALF: begin
        merged[hshift +: 16] = wdata[15:0];
        ext = {{16{sext & hval[15]}}, hval};
      end
      default: begin
        merged = wdata;
        ext    = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide Memory block: byte/half/word access,
// read-modify-write sub-word stores, sign/zero-extended sub-word loads.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEnable,
  input  logic [DATA_W-1:0] memReadData
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sext_q, sext_d;
  logic              trap;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] ext;

  mem_lane_merge u_lane (
    .size     (size_q),
    .off      (off_q),
    .sext     (sext_q),
    .old_word (memReadData),
    .wdata    (wdata_q),
    .merged   (merged),
    .ext      (ext)
  );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = misaligned(size, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign req_size = (size == SZ_RSVD) ? SZ_WORD : size;

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    off_d       = off_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    sext_d      = sext_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          off_d      = align_off(req_size, addr[1:0]);
          size_d     = req_size;
          wdata_d    = wdata;
          sext_d     = signExt;
          mem_addr_d = {2'b00, addr[ADDR_W-1:2]};
          rdata_d    = '0;
          if (trap) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else if (!we) begin
            state_d = ST_LOAD;
          end else if (req_size == SZ_WORD) begin
            state_d     = ST_WRITE;
            mem_wdata_d = wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = ext;
        ready_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_RMW_READ: begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        ready_d = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Write enable is high exactly while the state is WRITE, so async reset kills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      wdata_q     <= '0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      sext_q      <= sext_d;
    end
  end

  assign rdata          = rdata_q;
  assign ready          = ready_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign memAddress     = mem_addr_q;
  assign memWriteData   = mem_wdata_q;
  assign memWriteEnable = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        signExt = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic [31:0] memReadData;

  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          we_pulses = 0;
  int          ready_cnt = 0;
  logic [31:0] last_waddr = '0;
  int          lat;
  logic [31:0] rd;
  logic        e;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .signExt(signExt),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  assign memReadData = mem[memAddress[5:0]];

  always @(posedge clk) if (memWriteEnable) mem[memAddress[5:0]] <= memWriteData;

  always @(negedge clk) begin
    if (rst_n && memWriteEnable) begin
      we_pulses++;
      last_waddr = memAddress;
    end
    if (ready) ready_cnt++;
  end

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; signExt = sx; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = -1; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if ({ready, err, busy, memWriteEnable} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {ready, err, busy, memWriteEnable}); end
    checks++; if (memAddress !== 32'h0 || memWriteData !== 32'h0) begin errors++; $display("FAIL reset_mem_if got %h/%h exp 0/0", memAddress, memWriteData); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load;
    int p0;
    p0 = we_pulses;
    run_req(1'b1, 2'b10, 1'b0, 32'h3C, 32'h11223344);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
    checks++; if (we_pulses - p0 !== 1) begin errors++; $display("FAIL sw_we_pulses got %0d exp 1", we_pulses - p0); end
    checks++; if (last_waddr !== 32'h0F) begin errors++; $display("FAIL sw_mem_address got %h exp 0000000f", last_waddr); end
    checks++; if (mem[15] !== 32'h11223344) begin errors++; $display("FAIL sw_mem_word got %h exp 11223344", mem[15]); end
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_rdata_err got %h/%b exp 0/0", rd, e); end
    run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_rdata got %h exp 11223344", rd); end
  endtask

  task automatic test_byte;
    int p0;
    p0 = we_pulses;
    run_req(1'b1, 2'b00, 1'b0, 32'h3D, 32'hFFFFFFAA);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d exp 3", lat); end
    checks++; if (we_pulses - p0 !== 1) begin errors++; $display("FAIL sb_we_pulses got %0d exp 1", we_pulses - p0); end
    run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL sb_merged_word got %h exp 11aa3344", rd); end
    run_req(1'b0, 2'b00, 1'b1, 32'h3D, 32'h0);
    checks++; if (rd !== 32'hFFFFFFAA || lat !== 2) begin errors++; $display("FAIL lb_sext got %h lat %0d exp ffffffaa lat 2", rd, lat); end
    run_req(1'b0, 2'b00, 1'b0, 32'h3D, 32'h0);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lb_zext got %h exp 000000aa", rd); end
    run_req(1'b0, 2'b00, 1'b1, 32'h3F, 32'h0);
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL lb_off3 got %h exp 00000044", rd); end
  endtask

  task automatic test_half;
    run_req(1'b1, 2'b01, 1'b0, 32'h3E, 32'h1234BEEF);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d exp 3", lat); end
    checks++; if (mem[15] !== 32'h11AABEEF) begin errors++; $display("FAIL sh_mem_word got %h exp 11aabeef", mem[15]); end
    run_req(1'b0, 2'b01, 1'b1, 32'h3E, 32'h0);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_sext got %h exp ffffbeef", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h3C, 32'h0);
    checks++; if (rd !== 32'h000011AA) begin errors++; $display("FAIL lh_upper got %h exp 000011aa", rd); end
  endtask

  task automatic test_misalign;
    int p0;
    run_req(1'b0, 2'b10, 1'b0, 32'h3E, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_lw got lat %0d err %b rd %h exp lat 1 err 1 rd 0", lat, e, rd); end
`else
    checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h11AABEEF) begin errors++; $display("FAIL mis_lw got lat %0d err %b rd %h exp lat 2 err 0 rd 11aabeef", lat, e, rd); end
`endif
    p0 = we_pulses;
    run_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h00005566);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++; if (lat !== 1 || e !== 1'b1 || we_pulses != p0 || mem[16] !== 32'h0) begin errors++; $display("FAIL mis_sh got lat %0d err %b word %h exp lat 1 err 1 word 0", lat, e, mem[16]); end
`else
    checks++; if (lat !== 3 || e !== 1'b0 || mem[16] !== 32'h55660000) begin errors++; $display("FAIL mis_sh got lat %0d err %b word %h exp lat 3 err 0 word 55660000", lat, e, mem[16]); end
`endif
  endtask

  task automatic test_back_to_back;
    run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    // Still in DONE here: this request must be ignored.
    req = 1'b1; we = 1'b0; size = 2'b00; signExt = 1'b0; addr = 32'h3D;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignored got busy %b exp 0", busy); end
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
    @(negedge clk); @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== 32'h000000AA) begin errors++; $display("FAIL b2b_rdata got %b/%h exp 1/000000aa", ready, rdata); end
  endtask

  task automatic test_reset_mid;
    int r0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; signExt = 1'b0; addr = 32'h3C; wdata = 32'h77;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (memWriteEnable !== 1'b1) begin errors++; $display("FAIL rm_in_write got we %b exp 1", memWriteEnable); end
    r0 = ready_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if ({memWriteEnable, busy, ready} !== 3'b000 || memAddress !== 32'h0) begin errors++; $display("FAIL rm_async_clear got %b addr %h exp 000 addr 0", {memWriteEnable, busy, ready}, memAddress); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem[15] !== 32'h11AABEEF) begin errors++; $display("FAIL rm_no_commit got %h exp 11aabeef", mem[15]); end
    checks++; if (ready_cnt !== r0) begin errors++; $display("FAIL rm_no_ready got %0d exp %0d", ready_cnt, r0); end
    run_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    checks++; if (lat !== 2 || rd !== 32'h11AABEEF) begin errors++; $display("FAIL rm_next_req got lat %0d rd %h exp lat 2 rd 11aabeef", lat, rd); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    #1;
    test_reset();
    test_word_store_load();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
